alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised integer execution unit for the MIPS datapath. It replaces the purely combinational ALU with a registered, start/done-handshaked unit. It adds iterative multiply and divide, HI/LO registers, variable shifts, a write-enable for conditional moves, and a full flag set. It sits in the EX stage and stalls the pipeline through `busy`.

## Interface
- `WIDTH`, 32: operand/result width; must be ≥ 8 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only when `busy`=0.
- `op` in 5: internal opcode (`alu_pkg::alu_op_t`).
- `a` in WIDTH: operand A (rs).
- `b` in WIDTH: operand B (rt / immediate).
- `shamt` in SHW: shift amount for SLL/SRL/SRA.
- `busy` out 1: multi-cycle operation in progress.
- `done` out 1: one-cycle pulse; outputs below valid.
- `result` out WIDTH: registered result.
- `wr_en` out 1: destination register write enable, qualified by `done`.
- `hi`, `lo` out WIDTH: architectural HI/LO.
- `zero`, `negative`, `carry`, `overflow`, `div_by_zero` out 1: registered flags.

## Operation
- Single-cycle ops:
  - ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR.
  - SLT, SLTU: result 1 when a<b (signed/unsigned), else 0.
  - SLL/SRL/SRA use `shamt`; SLLV/SRLV/SRAV use `b[SHW-1:0]`.
  - CLO, CLZ: count of leading ones/zeros of `a`, range 0..WIDTH.
  - MOVN, MOVZ: result = a; `wr_en` = (b≠0) or (b==0) respectively.
  - MFHI, MFLO: result = hi/lo.
  - MTHI, MTLO: hi/lo := a; `wr_en`=0.
- Multi-cycle ops:
  - MULT, MULTU: shift-add over operand magnitudes; signed product negated at completion. {hi,lo} := 2·WIDTH product.
  - DIV, DIVU: restoring division over magnitudes. Quotient truncates toward zero, remainder takes the dividend's sign; lo := quotient, hi := remainder. MIN/−1 yields lo=MIN, hi=0.
  - For multi-cycle ops, `result` = new lo and `wr_en`=0.
- Divide by zero: completes as a single-cycle op; hi := a, lo := all ones, `div_by_zero`=1.
- `wr_en`=1 for every op that writes a GPR; 0 for MTHI/MTLO/MULT*/DIV* and for a failed MOVN/MOVZ.
- Flags are updated on every `done`:
  - `zero` = (result==0).
  - `negative` = result[WIDTH−1].
  - `carry` = carry-out for ADD/ADDU, borrow for SUB/SUBU, else 0.
  - `overflow` = signed overflow for ADD/SUB only, else 0.
  - `div_by_zero` is 0 except in the divide-by-zero case.
- FSM states: IDLE, MUL, DIV.
  - IDLE + start + mult op → MUL.
  - IDLE + start + div op with b≠0 → DIV.
  - MUL/DIV return to IDLE after WIDTH iterations.
  - Any other start stays in IDLE.
- `start` while `busy`=1 is ignored: no state change, no queuing.

## Timing
- Reset values: `busy`, `done`, `wr_en`, all flags = 0; `result`, `hi`, `lo` = 0; FSM = IDLE, iteration counter = 0.
- Reset asserted mid-operation aborts immediately. No `done` is produced; HI/LO are cleared.
- Single-cycle op: with start sampled at edge k, `done`=1 for the cycle after edge k. `busy` stays 0, so back-to-back starts are accepted every cycle.
- MUL/DIV: with start sampled at edge k, `busy`=1 from edge k through edge k+WIDTH. At edge k+WIDTH, hi/lo/result/flags are written, `done`=1 and `busy`=0. A new start is accepted in that same cycle.
- MFHI/MFLO issued the cycle `done` pulses read the just-written HI/LO.
- `done` never stays high for more than one consecutive cycle unless starts are back to back.

## Structure
- `alu_pkg` holds:
  - `alu_op_t`, a 5-bit enum of the 28 ops above.
  - `fsm_t`.
  - Helper functions `is_mul(op)`, `is_div(op)`, `is_signed(op)`.
  - Decode of funct/aluCode into `alu_op_t`, which lives in the control unit, not here.
- One sub-module, `alu_muldiv`: iterative multiplier/divider with its own counter, driven by start/op and returning hi/lo/done.
- The top level contains the combinational single-cycle datapath, the flag logic and the output registers.

## Test plan
- ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1, negative=1, carry=0, `done` one cycle after start. ADDU 0xFFFFFFFF+1 → result 0, zero=1, carry=1, overflow=0.
- MULT −3×7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB, `busy` high exactly 32 cycles, `done` at cycle 32. A start pulsed at cycle 5 is ignored. A following MFLO returns 0xFFFFFFEB.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after 32 cycles. DIVU 7/0 → `done` next cycle, div_by_zero=1, hi=7, lo=0xFFFFFFFF.
- CLZ 0x00010000 → 15; CLO 0xFFFFFFFF → 32; CLZ 0 → 32; SRAV a=0x80000000, b=0x24 → 0xF8000000 (shift 4).
- MOVN a=5, b=0 → `done`=1, `wr_en`=0. MOVZ a=5, b=0 → result 5, `wr_en`=1. MTHI 0x1234 then MFHI → 0x1234.
- `reset` raised 10 cycles into MULTU → `busy`=0, `done`=0, hi=lo=0 at once, with no later `done`. A start after release is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, FSM state types and op-class helpers for the multicycle ALU
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_CLO, OP_CLZ,
        OP_MOVN, OP_MOVZ,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, MUL, DIV} fsm_t;

    function automatic logic is_mul(input alu_op_t op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input alu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input alu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response bundle between the EX stage and the ALU
interface alu_multicycle_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    import alu_pkg::*;

    logic                 start;
    alu_op_t              op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [SHW-1:0]       shamt;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 wr_en;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic                 zero;
    logic                 negative;
    logic                 carry;
    logic                 overflow;
    logic                 div_by_zero;

    modport master (
        output start, op, a, b, shamt,
        input  busy, done, result, wr_en, hi, lo,
        input  zero, negative, carry, overflow, div_by_zero
    );

    modport slave (
        input  start, op, a, b, shamt,
        output busy, done, result, wr_en, hi, lo,
        output zero, negative, carry, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier and restoring divider over operand magnitudes
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    fsm_t             state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opB;
    logic             negLo;
    logic             negHi;

    logic             sgn;
    logic             launch;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic             divGeq;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;
    logic [2*WIDTH-1:0] prod;

    assign sgn    = is_signed(op);
    assign magA   = (sgn && a[WIDTH-1]) ? -a : a;
    assign magB   = (sgn && b[WIDTH-1]) ? -b : b;
    assign launch = start && (state == IDLE) && (is_mul(op) || (is_div(op) && (b != '0)));
    assign busy   = (state != IDLE);
    // done marks the final iteration; hi/lo are the finished values for the top to latch on this edge
    assign done   = busy && (count == CW'(WIDTH - 1));

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divGeq   = divShift >= {1'b0, opB};
        divRem   = divShift[WIDTH-1:0] - opB;
        if (state == MUL) begin
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end else begin
            nextHi = divGeq ? divRem : divShift[WIDTH-1:0];
            nextLo = {accLo[WIDTH-2:0], divGeq};
        end
    end

    always_comb begin
        prod = {nextHi, nextLo};
        if (negLo) begin
            prod = -prod;
        end
        if (state == MUL) begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end else begin
            lo = negLo ? -nextLo : nextLo;
            hi = negHi ? -nextHi : nextHi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            accHi <= '0;
            accLo <= '0;
            opB   <= '0;
            negLo <= 1'b0;
            negHi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        count <= '0;
                        accHi <= '0;
                        negLo <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        negHi <= sgn && a[WIDTH-1];
                        if (is_mul(op)) begin
                            state <= MUL;
                            accLo <= magB;
                            opB   <= magA;
                        end else begin
                            state <= DIV;
                            accLo <= magA;
                            opB   <= magB;
                        end
                    end
                end
                default: begin
                    accHi <= nextHi;
                    accLo <= nextLo;
                    count <= count + 1'b1;
                    if (done) begin
                        state <= IDLE;
                        count <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - EX-stage ALU: single-cycle datapath, flags, HI/LO and output registers
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    alu_multicycle_if.slave  bus
);
    logic             mdBusy;
    logic             mdDone;
    logic [WIDTH-1:0] mdHi;
    logic [WIDTH-1:0] mdLo;

    logic             doneReg, wrEnReg, zeroReg, negReg, carryReg, ovfReg, dbzReg;
    logic [WIDTH-1:0] resultReg, hiReg, loReg;

    logic [WIDTH-1:0] scResult, scHi, scLo;
    logic             scWrEn, scCarry, scOvf, scDbz, scWrHi, scWrLo, scDone;
    logic [WIDTH:0]   addSum, subDiff;
    logic [SHW-1:0]   varSh;

    alu_muldiv #(.WIDTH(WIDTH)) uMuldiv (
        .clk   (clk),
        .reset (reset),
        .start (bus.start),
        .op    (bus.op),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mdBusy),
        .done  (mdDone),
        .hi    (mdHi),
        .lo    (mdLo)
    );

    function automatic logic [WIDTH-1:0] leadCount(input logic [WIDTH-1:0] v, input logic bitVal);
        logic [WIDTH-1:0] n;
        logic             stop;
        n    = '0;
        stop = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!stop) begin
                if (v[i] == bitVal) n = n + 1'b1;
                else                stop = 1'b1;
            end
        end
        return n;
    endfunction

    assign addSum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign subDiff = {1'b0, bus.a} - {1'b0, bus.b};
    assign varSh   = bus.b[SHW-1:0];

    always_comb begin
        scResult = '0;
        scHi     = bus.a;
        scLo     = bus.a;
        scWrEn   = 1'b1;
        scCarry  = 1'b0;
        scOvf    = 1'b0;
        scDbz    = 1'b0;
        scWrHi   = 1'b0;
        scWrLo   = 1'b0;
        scDone   = 1'b1;
        case (bus.op)
            OP_ADD:  begin
                {scCarry, scResult} = addSum;
                scOvf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (addSum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: {scCarry, scResult} = addSum;
            OP_SUB:  begin
                {scCarry, scResult} = subDiff;
                scOvf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (subDiff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUBU: {scCarry, scResult} = subDiff;
            OP_AND:  scResult = bus.a & bus.b;
            OP_OR:   scResult = bus.a | bus.b;
            OP_XOR:  scResult = bus.a ^ bus.b;
            OP_NOR:  scResult = ~(bus.a | bus.b);
            OP_SLT:  scResult = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: scResult = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_SLL:  scResult = bus.a << bus.shamt;
            OP_SRL:  scResult = bus.a >> bus.shamt;
            OP_SRA:  scResult = $unsigned($signed(bus.a) >>> bus.shamt);
            OP_SLLV: scResult = bus.a << varSh;
            OP_SRLV: scResult = bus.a >> varSh;
            OP_SRAV: scResult = $unsigned($signed(bus.a) >>> varSh);
            OP_CLO:  scResult = leadCount(bus.a, 1'b1);
            OP_CLZ:  scResult = leadCount(bus.a, 1'b0);
            OP_MOVN: begin scResult = bus.a; scWrEn = (bus.b != '0); end
            OP_MOVZ: begin scResult = bus.a; scWrEn = (bus.b == '0); end
            OP_MFHI: scResult = hiReg;
            OP_MFLO: scResult = loReg;
            OP_MTHI: begin scResult = bus.a; scWrEn = 1'b0; scWrHi = 1'b1; end
            OP_MTLO: begin scResult = bus.a; scWrEn = 1'b0; scWrLo = 1'b1; end
            OP_MULT, OP_MULTU: begin scWrEn = 1'b0; scDone = 1'b0; end
            OP_DIV, OP_DIVU: begin
                scWrEn = 1'b0;
                // a zero divisor never enters the iterative unit; it resolves here in one cycle
                if (bus.b == '0) begin
                    scDbz    = 1'b1;
                    scWrHi   = 1'b1;
                    scWrLo   = 1'b1;
                    scLo     = '1;
                    scResult = '1;
                end else begin
                    scDone = 1'b0;
                end
            end
            default: scWrEn = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            doneReg   <= 1'b0;
            wrEnReg   <= 1'b0;
            zeroReg   <= 1'b0;
            negReg    <= 1'b0;
            carryReg  <= 1'b0;
            ovfReg    <= 1'b0;
            dbzReg    <= 1'b0;
            resultReg <= '0;
            hiReg     <= '0;
            loReg     <= '0;
        end else begin
            doneReg <= 1'b0;
            if (mdDone) begin
                doneReg   <= 1'b1;
                hiReg     <= mdHi;
                loReg     <= mdLo;
                resultReg <= mdLo;
                wrEnReg   <= 1'b0;
                zeroReg   <= (mdLo == '0);
                negReg    <= mdLo[WIDTH-1];
                carryReg  <= 1'b0;
                ovfReg    <= 1'b0;
                dbzReg    <= 1'b0;
            end else if (bus.start && !mdBusy && scDone) begin
                doneReg   <= 1'b1;
                resultReg <= scResult;
                wrEnReg   <= scWrEn;
                zeroReg   <= (scResult == '0);
                negReg    <= scResult[WIDTH-1];
                carryReg  <= scCarry;
                ovfReg    <= scOvf;
                dbzReg    <= scDbz;
                if (scWrHi) hiReg <= scHi;
                if (scWrLo) loReg <= scLo;
            end
        end
    end

    assign bus.busy        = mdBusy;
    assign bus.done        = doneReg;
    assign bus.result      = resultReg;
    assign bus.wr_en       = wrEnReg;
    assign bus.hi          = hiReg;
    assign bus.lo          = loReg;
    assign bus.zero        = zeroReg;
    assign bus.negative    = negReg;
    assign bus.carry       = carryReg;
    assign bus.overflow    = ovfReg;
    assign bus.div_by_zero = dbzReg;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed-vector self-checking bench for alu_multicycle
module tb_alu_multicycle;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   errCount;
    int   checkCount;

    alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input alu_op_t o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.shamt = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = -1;
        for (int c = 1; c <= WIDTH + 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic single(input string tag, input alu_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] s, input logic [31:0] expRes, input logic expWr);
        issue(o, x, y, s);
        check({tag, ".done"}, 64'(bus.done), 64'(1));
        check({tag, ".result"}, 64'(bus.result), 64'(expRes));
        check({tag, ".wr_en"}, 64'(bus.wr_en), 64'(expWr));
    endtask

    task automatic mulDiv(input string tag, input alu_op_t o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expHi, input logic [31:0] expLo);
        int cyc;
        issue(o, x, y, 5'd0);
        check({tag, ".busy"}, 64'(bus.busy), 64'(1));
        waitDone(cyc);
        check({tag, ".latency"}, 64'(cyc), 64'(WIDTH));
        check({tag, ".hi"}, 64'(bus.hi), 64'(expHi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(expLo));
        check({tag, ".result"}, 64'(bus.result), 64'(expLo));
        check({tag, ".wr_en"}, 64'(bus.wr_en), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int doneAt;
        int busyCnt;
        int lateDones;

        errCount   = 0;
        checkCount = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = OP_ADD;
        bus.a      = '0;
        bus.b      = '0;
        bus.shamt  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.done", 64'(bus.done), 64'(0));
        check("rst.result", 64'(bus.result), 64'(0));
        check("rst.hilo", {bus.hi, bus.lo}, 64'(0));
        check("rst.flags", 64'({bus.zero, bus.negative, bus.carry, bus.overflow, bus.div_by_zero, bus.wr_en}), 64'(0));

        single("add", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1);
        check("add.ovf", 64'(bus.overflow), 64'(1));
        check("add.neg", 64'(bus.negative), 64'(1));
        check("add.carry", 64'(bus.carry), 64'(0));
        @(posedge clk); #1;
        check("add.donePulse", 64'(bus.done), 64'(0));

        single("addu", OP_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);
        check("addu.zero", 64'(bus.zero), 64'(1));
        check("addu.carry", 64'(bus.carry), 64'(1));
        check("addu.ovf", 64'(bus.overflow), 64'(0));

        single("sub", OP_SUB, 32'h1, 32'h2, 5'd0, 32'hFFFF_FFFF, 1'b1);
        check("sub.borrow", 64'(bus.carry), 64'(1));
        check("sub.ovf", 64'(bus.overflow), 64'(0));
        single("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b1);
        single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1);

        // MULT -3 x 7 with a stray start during busy
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h7, 5'd0);
        busyCnt = bus.busy ? 1 : 0;
        doneAt  = -1;
        for (int c = 1; c <= WIDTH + 8; c++) begin
            if (c == 5) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.op    = OP_ADD;
                bus.a     = 32'h1;
                bus.b     = 32'h1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                doneAt = c;
                break;
            end
            if (bus.busy) busyCnt++;
        end
        check("mult.doneAt", 64'(doneAt), 64'(WIDTH));
        check("mult.busyCycles", 64'(busyCnt), 64'(WIDTH));
        check("mult.busyAtDone", 64'(bus.busy), 64'(0));
        check("mult.hi", 64'(bus.hi), 64'(32'hFFFF_FFFF));
        check("mult.lo", 64'(bus.lo), 64'(32'hFFFF_FFEB));
        single("mflo", OP_MFLO, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFEB, 1'b1);

        mulDiv("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        mulDiv("div", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        mulDiv("divNegDivisor", OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        mulDiv("divMin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        mulDiv("divu", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
        check("divu.dbz", 64'(bus.div_by_zero), 64'(0));

        single("divu0", OP_DIVU, 32'h7, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        check("divu0.dbz", 64'(bus.div_by_zero), 64'(1));
        check("divu0.hi", 64'(bus.hi), 64'(7));
        check("divu0.lo", 64'(bus.lo), 64'(32'hFFFF_FFFF));

        single("clz", OP_CLZ, 32'h0001_0000, 32'h0, 5'd0, 32'd15, 1'b1);
        single("clo", OP_CLO, 32'hFFFF_FFFF, 32'h0, 5'd0, 32'd32, 1'b1);
        single("clz0", OP_CLZ, 32'h0, 32'h0, 5'd0, 32'd32, 1'b1);
        single("srav", OP_SRAV, 32'h8000_0000, 32'h24, 5'd0, 32'hF800_0000, 1'b1);
        single("sll", OP_SLL, 32'h0000_0003, 32'h0, 5'd31, 32'h8000_0000, 1'b1);
        single("nor", OP_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 5'd0, 32'hF0F0_0F0F, 1'b1);

        single("movn", OP_MOVN, 32'h5, 32'h0, 5'd0, 32'h5, 1'b0);
        single("movz", OP_MOVZ, 32'h5, 32'h0, 5'd0, 32'h5, 1'b1);
        single("mthi", OP_MTHI, 32'h1234, 32'h0, 5'd0, 32'h1234, 1'b0);
        single("mfhi", OP_MFHI, 32'h0, 32'h0, 5'd0, 32'h1234, 1'b1);

        // reset in the middle of MULTU
        issue(OP_MULTU, 32'h0000_1234, 32'h0000_5678, 5'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.busy", 64'(bus.busy), 64'(0));
        check("abort.done", 64'(bus.done), 64'(0));
        check("abort.hilo", {bus.hi, bus.lo}, 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lateDones = 0;
        for (int c = 0; c < WIDTH + 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) lateDones++;
        end
        check("abort.lateDone", 64'(lateDones), 64'(0));
        single("afterReset", OP_ADD, 32'h2, 32'h3, 5'd0, 32'h5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
